// File: rtl/imem_load_arbiter.sv
// Instruction-memory port owner: streams a program in from the loader, then
// serves fetch reads for the core with alignment/range checking.
module imem_load_arbiter #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 100,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [WIDTH-1:0]  ld_data,
  input  logic              ld_last,
  input  logic              reload,
  input  logic [WIDTH-1:0]  fetch_pc,
  output logic [WIDTH-1:0]  fetch_instr,
  output logic              fetch_fault,
  output logic              cpu_run,
  output logic [ADDR_W:0]   loaded_words,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata
);

  typedef enum logic [1:0] {S_LOAD, S_DONE, S_RUN} state_t;

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   loaded_q, loaded_d;
  logic              fault_q, fault_d;
  logic              accept;
  logic              fetch_ok;

  assign accept = ld_valid && (state_q == S_LOAD);

  // Full-width compare so high PC bits can never alias into the array.
  assign fetch_ok = (fetch_pc[1:0] == 2'b00) &&
                    ((fetch_pc >> 2) < WIDTH'(loaded_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_LOAD;
      wr_ptr_q <= '0;
      loaded_q <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      loaded_q <= loaded_d;
      fault_q  <= fault_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    loaded_d = loaded_q;
    fault_d  = fault_q;
    case (state_q)
      S_LOAD: begin
        if (accept) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (ld_last || (wr_ptr_q == LAST_IDX)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        loaded_d = wr_ptr_q;
        fault_d  = 1'b0;
        state_d  = S_RUN;
      end
      S_RUN: begin
        if (reload) begin
          state_d  = S_LOAD;
          wr_ptr_d = '0;
          fault_d  = 1'b0;
        end else if (!fetch_ok) begin
          fault_d = 1'b1;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  assign ld_ready     = (state_q == S_LOAD);
  assign cpu_run      = (state_q == S_RUN);
  assign mem_we       = accept;
  assign mem_wdata    = ld_data;
  assign mem_addr     = (state_q == S_RUN) ? fetch_pc[ADDR_W+1:2] : wr_ptr_q[ADDR_W-1:0];
  assign fetch_instr  = ((state_q == S_RUN) && fetch_ok) ? mem_rdata : '0;
  assign fetch_fault  = fault_q;
  assign loaded_words = loaded_q;

endmodule
